pump_drive_guard: RTL and testbench
===================================

// Module: pump_drive_guard
// PURPOSE
// Downstream of the pump timer FSM: takes its 2-bit pump_out level as pump_req and drives the two pump MOSFET gates.
// Adds per-channel soft-start PWM ramp, inrush staggering, minimum off-time and a max-on-time watchdog with latched fault.
// Output pump_drv goes straight to board pins; status bits feed the LCD status page.
// PARAMETERS
// PWM_DIV        4          clk cycles per PWM count step (PWM frame = 256*PWM_DIV cycles)
// RAMP_START     8'd64      duty on RAMP entry (x/256)
// RAMP_STEP_CYC  400_000    cycles each duty level is held during ramp (+1 duty per step)
// MIN_OFF_CYC    200_000_000  minimum cycles a channel stays off after any stop (2 s @100 MHz)
// MAX_ON_CYC     32'd3_000_000_000  watchdog limit, cycles from RAMP entry (30 s @100 MHz)
// PORTS
// clk        in   1  system clock, 100 MHz
// rst_n      in   1  asynchronous, active-low reset
// pump_req   in   2  level request per channel (bit0 = ch0, bit1 = ch1), synchronous to clk
// drv_en     in   1  global enable; low stops all channels
// fault_clr  in   1  1-cycle pulse, clears latched faults
// pump_drv   out  2  registered gate drive (PWM during ramp, steady 1 when on)
// pump_on    out  2  channel fully on (state ON)
// fault      out  2  latched watchdog fault per channel
// BEHAVIOUR
// Reset: pump_drv=0, pump_on=0, fault=0, both channels OFF, all counters 0, pwm_cnt=0.
// PWM: shared free-running 8-bit pwm_cnt, +1 every PWM_DIV cycles, wraps 255->0.
// Per-channel FSM: OFF, RAMP, ON, COOLDOWN, FAULT.
//  OFF:      req=1 & drv_en & other channel not in RAMP -> RAMP; duty<=RAMP_START; step_cnt, on_cnt <= 0.
//            Both channels eligible in the same cycle: ch0 enters RAMP, ch1 waits in OFF until ch0 leaves RAMP.
//  RAMP:     drive = (pwm_cnt < duty). step_cnt reaching RAMP_STEP_CYC-1 -> duty+1, step_cnt<=0.
//            duty==255 at a step boundary -> ON.
//  ON:       drive = 1; pump_on=1.
//  RAMP/ON:  on_cnt +1 per cycle; req=0 or drv_en=0 -> COOLDOWN, off_cnt<=0.
//            on_cnt reaching MAX_ON_CYC-1 -> FAULT, fault bit set. Watchdog has priority over a req drop in the same cycle.
//  COOLDOWN: drive = 0; off_cnt +1. off_cnt reaching MIN_OFF_CYC-1 -> OFF.
//            req is ignored until then; if req is still 1, the OFF rules apply on the next cycle.
//  FAULT:    drive = 0; fault bit held. fault_clr -> COOLDOWN, fault<=0. fault_clr outside FAULT has no effect.
// Latency: pump_drv and pump_on are registered from the current state/duty, one cycle after the state change.
//  Example: req rises at cycle 0 -> state RAMP at cycle 1 -> first possible drive at cycle 2.
// Widths: on_cnt, off_cnt, step_cnt are 32-bit; comparisons are unsigned.
//  MAX_ON_CYC must be >= ramp length, else the watchdog trips during RAMP (legal; gives FAULT).
// drv_en=0: RAMP/ON -> COOLDOWN; OFF stays OFF; COOLDOWN and FAULT are unaffected.
// Async reset mid-operation: immediate return to reset values, including clearing faults.
// TESTING (PWM_DIV=1, RAMP_START=252, RAMP_STEP_CYC=4, MIN_OFF_CYC=10, MAX_ON_CYC=100)
// 1. req=01, drv_en=1 -> ch0 RAMP at cycle 1; duty 252..255 over 16 cycles, then ON.
//    pump_on[0]=1 one cycle later; pump_drv[0] steady 1.
// 2. req 01->00 while ON -> pump_drv[0]=0 next cycle; re-raise req after 3 cycles -> no RAMP until 10 COOLDOWN cycles elapse, then RAMP.
// 3. req=11 in the same cycle -> ch0 RAMP first; ch1 enters RAMP the cycle after ch0 reaches ON; never both in RAMP.
// 4. Hold req=01 for 150 cycles -> FAULT after 100 cycles from RAMP entry; fault=01, pump_drv[0]=0.
//    fault_clr pulse -> fault=00, 10-cycle COOLDOWN, then re-ramp while req=1.
// 5. drv_en 1->0 during ch1 RAMP -> pump_drv[1]=0 next cycle, COOLDOWN; drv_en back to 1 with req=10 -> RAMP after cooldown.
// 6. rst_n low mid-RAMP and in FAULT -> all outputs 0 asynchronously; after release, req=01 restarts the ramp from RAMP_START.

Source files
------------

// File: rtl/pump_drive_guard.sv
// pump_drive_guard: gate-drive guard between the pump timer FSM and the two
// pump MOSFET gates. Each channel gets a soft-start PWM ramp, inrush
// staggering against the other channel, a minimum off-time after any stop,
// and a max-on-time watchdog with a latched fault.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous, active-low reset
//   pump_req   in   2  level request per channel (bit0 = ch0, bit1 = ch1)
//   drv_en     in   1  global enable; low stops all running channels
//   fault_clr  in   1  single-cycle pulse, clears a latched fault
//   pump_drv   out  2  registered gate drive (PWM during ramp, 1 when on)
//   pump_on    out  2  registered, channel fully on
//   fault      out  2  latched watchdog fault per channel
module pump_drive_guard #(
  parameter int unsigned PWM_DIV       = 4,
  parameter logic [7:0]  RAMP_START    = 8'd64,
  parameter int unsigned RAMP_STEP_CYC = 400_000,
  parameter int unsigned MIN_OFF_CYC   = 200_000_000,
  parameter logic [31:0] MAX_ON_CYC    = 32'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pump_req,
  input  logic       drv_en,
  input  logic       fault_clr,
  output logic [1:0] pump_drv,
  output logic [1:0] pump_on,
  output logic [1:0] fault
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DUT_W = 8;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(PWM_DIV - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(RAMP_STEP_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = MAX_ON_CYC - CNT_W'(1);
  localparam logic [DUT_W-1:0] DUTY_MAX  = '1;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RAMP  = 3'd1,
    ST_ON    = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [DUT_W-1:0] duty_q  [NCH];
  logic [DUT_W-1:0] duty_d  [NCH];
  logic [CNT_W-1:0] step_q  [NCH];
  logic [CNT_W-1:0] step_d  [NCH];
  logic [CNT_W-1:0] on_q    [NCH];
  logic [CNT_W-1:0] on_d    [NCH];
  logic [CNT_W-1:0] off_q   [NCH];
  logic [CNT_W-1:0] off_d   [NCH];
  logic [NCH-1:0]   fault_d;
  logic [NCH-1:0]   grant_c;
  logic [NCH-1:0]   drv_c;
  logic [NCH-1:0]   on_c;

  logic [CNT_W-1:0] div_q;
  logic [DUT_W-1:0] pwm_q;

  // Shared free-running PWM counter, advanced once every PWM_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      pwm_q <= '0;
    end else if (div_q >= DIV_LAST) begin
      div_q <= '0;
      pwm_q <= pwm_q + DUT_W'(1);
    end else begin
      div_q <= div_q + CNT_W'(1);
    end
  end

  // Channel state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        duty_q[i]  <= '0;
        step_q[i]  <= '0;
        on_q[i]    <= '0;
        off_q[i]   <= '0;
      end
      fault <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        step_q[i]  <= step_d[i];
        on_q[i]    <= on_d[i];
        off_q[i]   <= off_d[i];
      end
      fault <= fault_d;
    end
  end

  // Ramp admission: only one channel may be ramping at a time; ch0 wins a tie.
  always_comb begin
    grant_c    = '0;
    grant_c[0] = (state_q[0] == ST_OFF) && pump_req[0] && drv_en &&
                 (state_q[1] != ST_RAMP);
    grant_c[1] = (state_q[1] == ST_OFF) && pump_req[1] && drv_en &&
                 (state_q[0] != ST_RAMP) && !grant_c[0];
  end

  // Per-channel next-state, counters and fault latch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      step_d[i]  = step_q[i];
      on_d[i]    = on_q[i];
      off_d[i]   = off_q[i];
    end
    fault_d = fault;

    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        ST_OFF: begin
          if (grant_c[i]) begin
            state_d[i] = ST_RAMP;
            duty_d[i]  = RAMP_START;
            step_d[i]  = '0;
            on_d[i]    = '0;
          end
        end

        ST_RAMP, ST_ON: begin
          on_d[i] = on_q[i] + CNT_W'(1);
          // Watchdog outranks a simultaneous stop request.
          if (on_q[i] >= ON_LAST) begin
            state_d[i] = ST_FAULT;
            fault_d[i] = 1'b1;
          end else if (!pump_req[i] || !drv_en) begin
            state_d[i] = ST_COOL;
            off_d[i]   = '0;
          end else if (state_q[i] == ST_RAMP) begin
            if (step_q[i] >= STEP_LAST) begin
              step_d[i] = '0;
              if (duty_q[i] == DUTY_MAX) begin
                state_d[i] = ST_ON;
              end else begin
                duty_d[i] = duty_q[i] + DUT_W'(1);
              end
            end else begin
              step_d[i] = step_q[i] + CNT_W'(1);
            end
          end
        end

        ST_COOL: begin
          off_d[i] = off_q[i] + CNT_W'(1);
          if (off_q[i] >= OFF_LAST) begin
            state_d[i] = ST_OFF;
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            state_d[i] = ST_COOL;
            off_d[i]   = '0;
            fault_d[i] = 1'b0;
          end
        end

        default: begin
          state_d[i] = ST_OFF;
        end
      endcase
    end
  end

  // Gate drive and on status derived from the current state and duty.
  always_comb begin
    drv_c = '0;
    on_c  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (state_q[i] == ST_RAMP) begin
        drv_c[i] = (pwm_q < duty_q[i]);
      end else if (state_q[i] == ST_ON) begin
        drv_c[i] = 1'b1;
        on_c[i]  = 1'b1;
      end
    end
  end

  // Output registers, one cycle behind the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_drv <= '0;
      pump_on  <= '0;
    end else begin
      pump_drv <= drv_c;
      pump_on  <= on_c;
    end
  end

endmodule

// File: tb/tb_pump_drive_guard.sv
// tb_pump_drive_guard: directed stimulus for pump_drive_guard with a
// cycle-level reference model feeding an expected-output queue, plus
// hand-timed checks on ramp length, cooldown, staggering, watchdog and reset.
module tb_pump_drive_guard;

  localparam int unsigned PWM_DIV       = 1;
  localparam logic [7:0]  RAMP_START    = 8'd252;
  localparam int unsigned RAMP_STEP_CYC = 4;
  localparam int unsigned MIN_OFF_CYC   = 10;
  localparam logic [31:0] MAX_ON_CYC    = 32'd100;

  localparam int S_OFF   = 0;
  localparam int S_RAMP  = 1;
  localparam int S_ON    = 2;
  localparam int S_COOL  = 3;
  localparam int S_FAULT = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] pump_req;
  logic       drv_en;
  logic       fault_clr;
  logic [1:0] pump_drv;
  logic [1:0] pump_on;
  logic [1:0] fault;

  typedef struct {
    logic [1:0] drv;
    logic [1:0] on;
    logic [1:0] flt;
  } exp_t;

  exp_t sb[$];

  int n_cmp;
  int n_err;

  // reference model state
  int ms    [2];
  int mduty [2];
  int mstep [2];
  int mon   [2];
  int moff  [2];
  bit mfault[2];
  int mpwm;

  pump_drive_guard #(
    .PWM_DIV      (PWM_DIV),
    .RAMP_START   (RAMP_START),
    .RAMP_STEP_CYC(RAMP_STEP_CYC),
    .MIN_OFF_CYC  (MIN_OFF_CYC),
    .MAX_ON_CYC   (MAX_ON_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pump_req (pump_req),
    .drv_en   (drv_en),
    .fault_clr(fault_clr),
    .pump_drv (pump_drv),
    .pump_on  (pump_on),
    .fault    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = S_OFF; mduty[i] = 0; mstep[i] = 0;
      mon[i] = 0; moff[i] = 0; mfault[i] = 1'b0;
    end
    mpwm = 0;
  endtask

  // One clock: predict the post-edge outputs, advance the model, then compare.
  task automatic tick(input string tag);
    exp_t e;
    exp_t got;
    bit   g[2];
    for (int i = 0; i < 2; i++) begin
      e.drv[i] = (ms[i] == S_RAMP) ? (mpwm < mduty[i]) : (ms[i] == S_ON);
      e.on[i]  = (ms[i] == S_ON);
    end
    g[0] = (ms[0] == S_OFF) && pump_req[0] && drv_en && (ms[1] != S_RAMP);
    g[1] = (ms[1] == S_OFF) && pump_req[1] && drv_en && (ms[0] != S_RAMP) && !g[0];
    for (int i = 0; i < 2; i++) begin
      case (ms[i])
        S_OFF: if (g[i]) begin
          ms[i] = S_RAMP; mduty[i] = int'(RAMP_START); mstep[i] = 0; mon[i] = 0;
        end
        S_RAMP, S_ON: begin
          if (mon[i] == int'(MAX_ON_CYC) - 1) begin
            ms[i] = S_FAULT; mfault[i] = 1'b1;
          end else if (!pump_req[i] || !drv_en) begin
            ms[i] = S_COOL; moff[i] = 0;
          end else if (ms[i] == S_RAMP) begin
            if (mstep[i] == int'(RAMP_STEP_CYC) - 1) begin
              mstep[i] = 0;
              if (mduty[i] == 255) ms[i] = S_ON;
              else mduty[i]++;
            end else begin
              mstep[i]++;
            end
          end
          mon[i]++;
        end
        S_COOL: begin
          if (moff[i] == int'(MIN_OFF_CYC) - 1) ms[i] = S_OFF;
          moff[i]++;
        end
        S_FAULT: if (fault_clr) begin
          ms[i] = S_COOL; moff[i] = 0; mfault[i] = 1'b0;
        end
        default: ms[i] = S_OFF;
      endcase
      e.flt[i] = mfault[i];
    end
    mpwm = (mpwm + 1) % 256;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 2'b00, 2'b11);
    end else begin
      got = sb.pop_front();
      chk({tag, "_drv"}, pump_drv, got.drv);
      chk({tag, "_on"}, pump_on, got.on);
      chk({tag, "_fault"}, fault, got.flt);
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    pump_req  = 2'b00;
    drv_en    = 1'b0;
    fault_clr = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_drv", pump_drv, 2'b00);
    chk("rst_on", pump_on, 2'b00);
    chk("rst_fault", fault, 2'b00);
    #2 rst_n = 1'b1;

    // idle so the ramp overlaps the top of the PWM frame
    drv_en = 1'b1;
    ticks(240, "idle");

    // 1: single-channel ramp 252..255, then ON
    pump_req = 2'b01;
    ticks(17, "t1_ramp");
    chk("t1_on_early", pump_on, 2'b00);
    tick("t1_on_edge");
    chk("t1_on", pump_on, 2'b01);
    chk("t1_drv_steady", pump_drv, 2'b01);
    fault_clr = 1'b1;
    tick("t1_clr_no_fault");
    fault_clr = 1'b0;
    chk("t1_clr_noeffect", fault, 2'b00);
    ticks(3, "t1_hold");

    // 2: stop, early re-request held off by cooldown
    pump_req = 2'b00;
    ticks(2, "t2_stop");
    chk("t2_drv_off", pump_drv, 2'b00);
    tick("t2_cool");
    pump_req = 2'b01;
    ticks(25, "t2_wait");
    chk("t2_on_early", pump_on, 2'b00);
    tick("t2_on_edge");
    chk("t2_on", pump_on, 2'b01);

    // 3: simultaneous request, ch1 staggered behind ch0
    pump_req = 2'b00;
    ticks(12, "t3_cool");
    pump_req = 2'b11;
    ticks(34, "t3_ramp");
    chk("t3_ch0_only", pump_on, 2'b01);
    tick("t3_ch1_edge");
    chk("t3_both_on", pump_on, 2'b11);

    // 4: watchdog fault, clear, re-ramp
    pump_req = 2'b00;
    ticks(12, "t4_cool");
    pump_req = 2'b01;
    ticks(100, "t4_run");
    chk("t4_no_fault_yet", fault, 2'b00);
    tick("t4_trip");
    chk("t4_fault", fault, 2'b01);
    tick("t4_after");
    chk("t4_drv_off", pump_drv, 2'b00);
    ticks(48, "t4_hold");
    chk("t4_fault_held", fault, 2'b01);
    fault_clr = 1'b1;
    tick("t4_clr");
    fault_clr = 1'b0;
    chk("t4_fault_cleared", fault, 2'b00);
    ticks(27, "t4_recool");
    chk("t4_on_early", pump_on, 2'b00);
    tick("t4_on_edge");
    chk("t4_on", pump_on, 2'b01);

    // 5: drv_en drop during ch1 ramp
    pump_req = 2'b00;
    ticks(12, "t5_cool");
    pump_req = 2'b10;
    ticks(5, "t5_ramp");
    drv_en = 1'b0;
    ticks(2, "t5_disable");
    chk("t5_drv_off", pump_drv, 2'b00);
    ticks(2, "t5_off");
    drv_en = 1'b1;
    ticks(24, "t5_wait");
    chk("t5_on_early", pump_on, 2'b00);
    tick("t5_on_edge");
    chk("t5_on", pump_on, 2'b10);

    // 6: async reset mid-ramp, then in FAULT
    pump_req = 2'b00;
    ticks(12, "t6_cool");
    pump_req = 2'b01;
    ticks(6, "t6_ramp");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_drv", pump_drv, 2'b00);
    chk("t6_rst_on", pump_on, 2'b00);
    chk("t6_rst_fault", fault, 2'b00);
    model_reset();
    sb.delete();
    #1 rst_n = 1'b1;
    ticks(17, "t6_reramp");
    chk("t6_on_early", pump_on, 2'b00);
    tick("t6_on_edge");
    chk("t6_on", pump_on, 2'b01);
    ticks(83, "t6_run");
    chk("t6_fault", fault, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_fault_clr", fault, 2'b00);
    chk("t6_rst_drv2", pump_drv, 2'b00);
    chk("t6_rst_on2", pump_on, 2'b00);
    model_reset();
    sb.delete();
    #1 rst_n = 1'b1;
    pump_req = 2'b00;
    ticks(3, "t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
